instr_stream_loader: RTL and testbench
======================================

# instr_stream_loader

Sequential instruction encoder and boot loader for the RV32I core; the producing end of the opcode/field interface that the core's control decoding consumes. It accepts decoded instruction fields (class, registers, funct3, immediate) over a valid/ready handshake and encodes each into a 32-bit RV32I word. Supported classes are load, store, R-type, I-type ALU and branch. Each word is written into instruction memory at consecutive word addresses from 0. The core is held in reset until the program is fully loaded, then released.

## Interface
Parameters:
- DEPTH, 1024: instruction memory capacity in words.
- ADDR_W, 10: log2(DEPTH).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  loader can accept a bundle this cycle.
- in_class  in  3  instruction class: 000 load, 001 store, 010 R-type, 011 I-type ALU, 100 branch; 101–111 illegal.
- in_funct3  in  3  funct3 field.
- in_funct7b5  in  1  bit 30 for R-type (sub/sra); ignored for other classes.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  13  signed immediate. Branch uses a 13-bit byte offset; all other classes use bits [11:0].
- in_last  in  1  the bundle is the final instruction of the program.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  32  byte address, word-aligned ({count, 2'b00} zero-extended).
- mem_wdata  out  32  encoded instruction.
- core_rst  out  1  active-low reset to the core; low until loading completes.
- done  out  1  program loaded.
- count  out  ADDR_W+1  number of words written so far.
- err  out  1  sticky error flag.

## Operation
- States: LOAD, FLUSH, DONE. Reset enters LOAD.
- A transfer occurs when in_valid and in_ready are both high at a rising edge.
- in_ready = (state==LOAD) and (words accepted < DEPTH).

Encoding (registered into mem_wdata on acceptance):
- load: {imm[11:0], rs1, f3, rd, 0000011}.
- store: {imm[11:5], rs2, rs1, f3, imm[4:0], 0100011}.
- R-type: {0, funct7b5, 00000, rs2, rs1, f3, rd, 0110011}.
- I-type ALU: {imm[11:0], rs1, f3, rd, 0010011}.
- branch: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 1100011}.
- Illegal class: word 0x00000013 (nop) is written in place; err set.
- Branch with imm[0]=1: imm[0] is dropped, encoding proceeds, err set.
- err clears only on reset.

Write and state transitions:
- Each accepted bundle produces exactly one memory write on the following cycle; count increments in the same cycle as that write.
- in_last accepted, or the DEPTH-th word accepted: LOAD→FLUSH. The final write occurs in FLUSH, then FLUSH→DONE.
- DONE: in_ready=0, mem_we=0, done=1, core_rst=1. The block stays in DONE until reset.
- Words beyond DEPTH are never accepted. If in_last never arrives, the DEPTH-th acceptance acts as last.

Reset values: in_ready=1 once reset deasserts, mem_we=0, mem_addr=0, mem_wdata=0, count=0, done=0, core_rst=0, err=0.

## Timing
- Latency: acceptance at edge k gives mem_we=1, with valid mem_addr/mem_wdata, for the cycle after edge k. The memory samples the write at edge k+1.
- All outputs are registered; no combinational path from in_* to mem_* outputs.
- in_ready depends only on state and count, never on in_valid.
- Throughput: one word per cycle under back-to-back valid.
- Holes in in_valid produce mem_we=0 cycles. mem_addr holds the next write address while idle.
- done and core_rst rise together, one cycle after the final mem_we cycle.
- Reset mid-operation (any state, any phase): immediate return to reset values.
  - An in-flight write is dropped: mem_we falls asynchronously.
  - core_rst returns low.
  - Loading restarts at address 0.

## Test plan
- Accept lw x6,-4(x9): class 000, rd 6, rs1 9, f3 010, imm 0x1FFC → next cycle mem_we=1, addr 0x0, wdata 0xFFC4A303; count=1.
- Back-to-back stream, one cycle each, last on the final bundle:
  - sw x6,8(x9) → 0x0064A423 at addr 0.
  - or x4,x5,x6 → 0x0062E233 at addr 4.
  - beq x4,x4,+8 → 0x00420463 at addr 8.
  - addi x5,x0,10 → 0x00A00293 at addr 0xC.
  - Required: four consecutive mem_we cycles, then done=1 and core_rst=1 the following cycle, count=4.
- Illegal class 110 → 0x00000013 written and err=1. Then a branch with imm=0x005 → written with imm[0] cleared, err stays 1.
- With DEPTH=4 and no in_last: after the 4th acceptance in_ready=0, a 5th in_valid is ignored, and done rises one cycle after the 4th write.
- Drive rst low during the cycle mem_we=1 for the 3rd word:
  - Immediately: mem_we=0, count=0, core_rst=0.
  - After release, the next accepted bundle is written at addr 0.
- Idle gaps: valid pulses every third cycle → mem_we pulses every third cycle with addresses 0,4,8. No write occurs without a preceding acceptance.

Source files
------------

// File: rtl/instr_stream_loader.sv
// RV32I instruction encoder and boot loader: encodes field bundles into words,
// writes them to instruction memory from address 0, then releases the core.
module instr_stream_loader #(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_class,
   input  logic [2:0]        in_funct3,
   input  logic              in_funct7b5,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [12:0]       in_imm,
   input  logic              in_last,
   output logic              mem_we,
   output logic [31:0]       mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_rst,
   output logic              done,
   output logic [ADDR_W:0]   count,
   output logic              err
);

   typedef enum logic [1:0] {S_LOAD, S_FLUSH, S_DONE} state_e;

   localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
   localparam logic [31:0]     NOP      = 32'h0000_0013;

   state_e           state_q, state_d;
   logic [ADDR_W:0]  count_q;
   logic             mem_we_q;
   logic [31:0]      mem_addr_q;
   logic [31:0]      mem_wdata_q;
   logic             err_q;
   logic             done_q;

   logic             accept;
   logic [31:0]      enc_word;
   logic             enc_err;

   assign in_ready = (state_q == S_LOAD) && (count_q < DEPTH_W);
   assign accept   = in_valid && in_ready;

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case leaves it unassigned and infers a latch.
   always_comb begin
      enc_word = NOP;
      enc_err  = 1'b0;
      unique case (in_class)
         3'b000: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
         3'b001: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
         3'b010: enc_word = {1'b0, in_funct7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
         3'b011: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
         3'b100: begin
            // Misaligned branch offset: bit 0 has no slot in the encoding anyway.
            enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], 7'b1100011};
            enc_err  = in_imm[0];
         end
         default: enc_err = 1'b1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_LOAD:  if (accept && (in_last || count_q == LAST_IDX)) state_d = S_FLUSH;
         S_FLUSH: state_d = S_DONE;
         default: state_d = S_DONE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_LOAD;
         count_q     <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         mem_we_q   <= accept;
         // Write address while writing, next free address while idle.
         mem_addr_q <= 32'({count_q, 2'b00});
         done_q     <= (state_d == S_DONE);
         if (accept) begin
            count_q     <= count_q + 1'b1;
            mem_wdata_q <= enc_word;
            if (enc_err) err_q <= 1'b1;
         end
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign count     = count_q;
   assign err       = err_q;
   assign done      = done_q;
   assign core_rst  = done_q;

endmodule

// File: tb/tb_instr_stream_loader.sv
// Directed bench for instr_stream_loader: encoding table, streaming, depth
// limit, idle gaps and asynchronous reset mid-load.
module tb_instr_stream_loader;

   typedef struct {
      logic [2:0]  cls;
      logic [2:0]  f3;
      logic        f7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [12:0] imm;
      logic [31:0] exp_word;
      logic        exp_err;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [2:0]  in_class = '0;
   logic [2:0]  in_funct3 = '0;
   logic        in_funct7b5 = 1'b0;
   logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [12:0] in_imm = '0;
   logic        in_last = 1'b0;

   logic        in_ready, mem_we, core_rst, done, err;
   logic [31:0] mem_addr, mem_wdata;
   logic [10:0] count;

   logic        in_ready4, mem_we4, core_rst4, done4, err4;
   logic [31:0] mem_addr4, mem_wdata4;
   logic [2:0]  count4;

   int n_total = 0;
   int n_pass  = 0;

   vec_t vecs[11];

   always #5 clk = ~clk;

   instr_stream_loader dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_class(in_class), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .core_rst(core_rst), .done(done),
      .count(count), .err(err)
   );

   instr_stream_loader #(.DEPTH(4), .ADDR_W(2)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
      .in_class(in_class), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .in_last(in_last), .mem_we(mem_we4), .mem_addr(mem_addr4),
      .mem_wdata(mem_wdata4), .core_rst(core_rst4), .done(done4),
      .count(count4), .err(err4)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic drive(input vec_t v, input logic last);
      in_valid    = 1'b1;
      in_class    = v.cls;
      in_funct3   = v.f3;
      in_funct7b5 = v.f7;
      in_rd       = v.rd;
      in_rs1      = v.rs1;
      in_rs2      = v.rs2;
      in_imm      = v.imm;
      in_last     = last;
   endtask

   task automatic reset_all();
      in_valid = 1'b0;
      in_last  = 1'b0;
      rst      = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      //                cls     f3      f7    rd     rs1    rs2    imm         word          err
      vecs[0]  = '{3'b000, 3'b010, 1'b0, 5'd6,  5'd9,  5'd0,  13'h1FFC, 32'hFFC4A303, 1'b0}; // lw x6,-4(x9)
      vecs[1]  = '{3'b001, 3'b010, 1'b0, 5'd0,  5'd9,  5'd6,  13'h0008, 32'h0064A423, 1'b0}; // sw x6,8(x9)
      vecs[2]  = '{3'b010, 3'b110, 1'b0, 5'd4,  5'd5,  5'd6,  13'h0000, 32'h0062E233, 1'b0}; // or x4,x5,x6
      vecs[3]  = '{3'b100, 3'b000, 1'b0, 5'd0,  5'd4,  5'd4,  13'h0008, 32'h00420463, 1'b0}; // beq x4,x4,+8
      vecs[4]  = '{3'b011, 3'b000, 1'b0, 5'd5,  5'd0,  5'd0,  13'h000A, 32'h00A00293, 1'b0}; // addi x5,x0,10
      vecs[5]  = '{3'b010, 3'b000, 1'b1, 5'd1,  5'd2,  5'd3,  13'h0000, 32'h403100B3, 1'b0}; // sub x1,x2,x3
      vecs[6]  = '{3'b100, 3'b100, 1'b0, 5'd0,  5'd1,  5'd2,  13'h1FFC, 32'hFE20CEE3, 1'b0}; // blt x1,x2,-4
      vecs[7]  = '{3'b011, 3'b111, 1'b0, 5'd7,  5'd8,  5'd0,  13'h1FFF, 32'hFFF47393, 1'b0}; // andi x7,x8,-1
      vecs[8]  = '{3'b011, 3'b000, 1'b1, 5'd1,  5'd1,  5'd0,  13'h0001, 32'h00108093, 1'b0}; // addi, f7b5 ignored
      vecs[9]  = '{3'b110, 3'b101, 1'b1, 5'd31, 5'd31, 5'd31, 13'h1FFF, 32'h00000013, 1'b1}; // illegal -> nop
      vecs[10] = '{3'b100, 3'b000, 1'b0, 5'd0,  5'd0,  5'd0,  13'h0005, 32'h00000263, 1'b1}; // odd branch offset

      // Reset state
      reset_all();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_mem_we",   32'(mem_we),   32'd0);
      check("rst_mem_addr", mem_addr,      32'd0);
      check("rst_wdata",    mem_wdata,     32'd0);
      check("rst_count",    32'(count),    32'd0);
      check("rst_done",     32'(done),     32'd0);
      check("rst_core_rst", 32'(core_rst),  32'd0);
      check("rst_err",      32'(err),      32'd0);

      // Encoding table, back-to-back, no last
      for (int i = 0; i < 11; i++) begin
         drive(vecs[i], 1'b0);
         @(negedge clk);
         check($sformatf("tbl%0d_we", i),    32'(mem_we), 32'd1);
         check($sformatf("tbl%0d_addr", i),  mem_addr,    32'(4 * i));
         check($sformatf("tbl%0d_wdata", i), mem_wdata,   vecs[i].exp_word);
         check($sformatf("tbl%0d_count", i), 32'(count),  32'(i + 1));
         check($sformatf("tbl%0d_err", i),   32'(err),    32'(vecs[i].exp_err));
      end
      in_valid = 1'b0;
      check("tbl_ready_after", 32'(in_ready), 32'd1);
      check("tbl_done_after",  32'(done),     32'd0);

      // Four-word program with last on the final bundle
      reset_all();
      for (int i = 0; i < 4; i++) begin
         drive(vecs[i + 1], i == 3);
         @(negedge clk);
         check($sformatf("str%0d_we", i),    32'(mem_we), 32'd1);
         check($sformatf("str%0d_addr", i),  mem_addr,    32'(4 * i));
         check($sformatf("str%0d_wdata", i), mem_wdata,   vecs[i + 1].exp_word);
         check($sformatf("str%0d_done", i),  32'(done),   32'd0);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("str_ready_flush", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("str_done",      32'(done),     32'd1);
      check("str_core_rst",  32'(core_rst), 32'd1);
      check("str_count",     32'(count),    32'd4);
      check("str_we_idle",   32'(mem_we),   32'd0);
      check("str_ready_dn",  32'(in_ready), 32'd0);
      drive(vecs[4], 1'b0);
      @(negedge clk);
      check("str_done_hold", 32'(mem_we),   32'd0);
      check("str_cnt_hold",  32'(count),    32'd4);
      rst = 1'b0;
      #1;
      check("str_rst_core", 32'(core_rst), 32'd0);
      check("str_rst_done", 32'(done),     32'd0);
      check("str_rst_cnt",  32'(count),    32'd0);

      // DEPTH=4 instance without in_last
      reset_all();
      for (int i = 0; i < 4; i++) begin
         drive(vecs[4], 1'b0);
         @(negedge clk);
         check($sformatf("d4_%0d_we", i),   32'(mem_we4), 32'd1);
         check($sformatf("d4_%0d_addr", i), mem_addr4,    32'(4 * i));
      end
      check("d4_ready_full", 32'(in_ready4), 32'd0);
      check("d4_count_full", 32'(count4),    32'd4);
      check("d4_done_early", 32'(done4),     32'd0);
      @(negedge clk);  // fifth in_valid still high
      in_valid = 1'b0;
      check("d4_5th_ignored", 32'(mem_we4),   32'd0);
      check("d4_done",        32'(done4),     32'd1);
      check("d4_core_rst",    32'(core_rst4), 32'd1);
      check("d4_count_hold",  32'(count4),    32'd4);

      // Asynchronous reset while the third word is being written
      reset_all();
      for (int i = 0; i < 3; i++) begin
         drive(vecs[i], 1'b0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("mid_we_before",   32'(mem_we), 32'd1);
      check("mid_addr_before", mem_addr,    32'd8);
      rst = 1'b0;
      #1;
      check("mid_we",       32'(mem_we),   32'd0);
      check("mid_count",    32'(count),    32'd0);
      check("mid_core_rst", 32'(core_rst), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      drive(vecs[2], 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      check("mid_re_we",    32'(mem_we), 32'd1);
      check("mid_re_addr",  mem_addr,    32'd0);
      check("mid_re_wdata", mem_wdata,   vecs[2].exp_word);

      // Valid every third cycle
      reset_all();
      for (int i = 0; i < 3; i++) begin
         drive(vecs[i], 1'b0);
         @(negedge clk);
         in_valid = 1'b0;
         check($sformatf("gap%0d_we", i),      32'(mem_we), 32'd1);
         check($sformatf("gap%0d_addr", i),    mem_addr,    32'(4 * i));
         @(negedge clk);
         check($sformatf("gap%0d_idle", i),    32'(mem_we), 32'd0);
         check($sformatf("gap%0d_nxt", i),     mem_addr,    32'(4 * (i + 1)));
         @(negedge clk);
         check($sformatf("gap%0d_idle2", i),   32'(mem_we), 32'd0);
      end
      check("gap_count", 32'(count), 32'd3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
